// File: rtl/grey_pkg.sv
// Shared Gray-code helpers for the encoder/decoder pair.
package grey_pkg;

    // Widest code word any user of this package may instantiate.
    localparam int MAXW = 32;

    // Number of set bits; used to measure how far a Gray sample moved.
    function automatic logic [5:0] popcount(input logic [MAXW-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < MAXW; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // Decodes a right-aligned Gray slice. msb is the already-decoded binary
    // bit sitting just above the slice (0 for the top slice). Zero padding
    // above the slice leaves the running XOR untouched.
    function automatic logic [MAXW-1:0] grey2bin_slice(input logic [MAXW-1:0] g,
                                                      input logic            msb);
        logic [MAXW-1:0] b;
        logic            acc;
        acc = msb;
        for (int i = MAXW - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

    // Binary-to-Gray, used by the companion encoder.
    function automatic logic [MAXW-1:0] bin2grey(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/grey2nature_stage.sv
// One decoder pipeline register: resolves bits HI..LO of the word, leaving
// bits above already binary and bits below still Gray. HI < 0 means pass-through.
module grey2nature_stage
    import grey_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int HI    = 4,
    parameter int LO    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_err,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_word,
    output logic             o_err
);
    localparam int N = (HI >= LO) ? (HI - LO + 1) : 1;

    logic             r_valid;
    logic [WIDTH-1:0] r_word;
    logic             r_err;
    logic [WIDTH-1:0] w_next;

    generate
        if (HI < 0) begin : g_pass
            assign w_next = i_word;
        end else begin : g_dec
            logic         w_carry;
            logic [N-1:0] w_bin;
            if (HI == WIDTH - 1) begin : g_top
                assign w_carry = 1'b0;
            end else begin : g_low
                assign w_carry = i_word[HI+1];
            end
            assign w_bin = N'(grey2bin_slice(MAXW'(i_word[HI:LO]), w_carry));
            // Splice the decoded slice into the partially decoded word.
            always_comb begin
                w_next        = i_word;
                w_next[HI:LO] = w_bin;
            end
        end
    endgenerate

    // Stage register; data only changes when a real word enters so the
    // output holds steady under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_word  <= '0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_word <= w_next;
                r_err  <= i_err;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;
    assign o_err   = r_err;

endmodule

// File: rtl/grey2nature.sv
// Pipelined Gray-to-binary decoder with valid/ready flow control and a
// single-step integrity check on every accepted sample.
module grey2nature
    import grey_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] grey,
    input  logic             err_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] nature,
    output logic             out_step_err,
    output logic             err_sticky
);
    // Bits resolved per stage; late stages may get none and just pass data.
    localparam int C = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES:0]   w_vld;
    logic [STAGES:0]   w_err;
    logic [WIDTH-1:0]  w_word [STAGES+1];
    logic [STAGES-1:0] w_load;
    logic              w_chain;
    logic              w_acc;
    logic              w_err_in;
    logic [5:0]        w_dist;

    logic [WIDTH-1:0]  r_prev_grey;
    logic              r_armed;
    logic              r_sticky;

    assign w_vld[0]  = in_valid;
    assign w_word[0] = grey;
    assign w_err[0]  = w_err_in;

    // Ready chain: a stage may load if it or any stage downstream has room,
    // or the consumer is draining the last stage.
    always_comb begin
        w_chain = out_ready;
        w_load  = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            w_chain   = w_chain || !w_vld[s+1];
            w_load[s] = w_chain;
        end
    end

    assign in_ready = w_load[0];
    assign w_acc    = in_valid && w_load[0];

    // A clear in the same cycle makes this sample the new first sample.
    assign w_dist   = popcount(MAXW'(grey ^ r_prev_grey));
    assign w_err_in = r_armed && !err_clr && (w_dist > 6'd1);

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            localparam int HI     = WIDTH - 1 - s * C;
            localparam int LO_RAW = WIDTH - (s + 1) * C;
            localparam int LO     = (LO_RAW > 0) ? LO_RAW : 0;
            grey2nature_stage #(
                .WIDTH (WIDTH),
                .HI    (HI),
                .LO    (LO)
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_load[s]),
                .i_valid (w_vld[s]),
                .i_word  (w_word[s]),
                .i_err   (w_err[s]),
                .o_valid (w_vld[s+1]),
                .o_word  (w_word[s+1]),
                .o_err   (w_err[s+1])
            );
        end
    endgenerate

    // Step-check history and sticky error; err_clr wins over a new error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_grey <= '0;
            r_armed     <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            if (w_acc) begin
                r_prev_grey <= grey;
            end
            if (err_clr) begin
                r_sticky <= 1'b0;
                r_armed  <= w_acc;
            end else if (w_acc) begin
                r_armed <= 1'b1;
                if (w_err_in) begin
                    r_sticky <= 1'b1;
                end
            end
        end
    end

    assign out_valid    = w_vld[STAGES];
    assign nature       = w_word[STAGES];
    assign out_step_err = w_err[STAGES];
    assign err_sticky   = r_sticky;

endmodule

// File: tb/tb_grey2nature.sv
`timescale 1ns/1ps
// Self-checking bench for grey2nature: main instance WIDTH=5/STAGES=2 plus
// STAGES=1 and STAGES=WIDTH instances for the parameter corners.
module tb_grey2nature;
    localparam int W = 5;
    localparam int S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, err_clr, out_valid, out_ready;
    logic         out_step_err, err_sticky;
    logic [W-1:0] grey, nature;

    logic         c_valid;
    logic [W-1:0] c_grey;
    logic         c1_ready, c1_ov, c1_serr, c1_stk;
    logic         c5_ready, c5_ov, c5_serr, c5_stk;
    logic [W-1:0] c1_nat, c5_nat;

    grey2nature #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .grey(grey), .err_clr(err_clr), .out_valid(out_valid), .out_ready(out_ready),
        .nature(nature), .out_step_err(out_step_err), .err_sticky(err_sticky));

    grey2nature #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c1_ready),
        .grey(c_grey), .err_clr(1'b0), .out_valid(c1_ov), .out_ready(1'b1),
        .nature(c1_nat), .out_step_err(c1_serr), .err_sticky(c1_stk));

    grey2nature #(.WIDTH(W), .STAGES(W)) dut_s5 (
        .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c5_ready),
        .grey(c_grey), .err_clr(1'b0), .out_valid(c5_ov), .out_ready(1'b1),
        .nature(c5_nat), .out_step_err(c5_serr), .err_sticky(c5_stk));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] nat;
        logic         err;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_prev;
    logic         m_armed, m_sticky;

    // Reference decode: the binary value whose Gray encoding equals g.
    function automatic logic [W-1:0] nature_of(input logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++) begin
            logic [W-1:0] bb;
            bb = W'(b);
            if ((bb ^ (bb >> 1)) == g) return bb;
        end
        return '0;
    endfunction

    function automatic logic [W-1:0] gray_of(input int n);
        logic [W-1:0] b;
        b = W'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        grey = '0; c_valid = 1'b0; c_grey = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        m_prev = '0; m_armed = 1'b0; m_sticky = 1'b0;
    endtask

    // One clock of stimulus; samples the DUT at the falling edge and keeps
    // the reference model (expected words, step history, sticky flag).
    task automatic step(input logic v, input logic [W-1:0] g, input logic clr,
                        input logic ordy, output logic rdy, output logic ov,
                        output logic [W-1:0] got_nat, output logic got_err,
                        output logic [W-1:0] exp_nat, output logic exp_err,
                        output logic stk, output logic exp_stk, output int occ);
        exp_t e;
        logic acc_err;
        in_valid = v; grey = g; err_clr = clr; out_ready = ordy;
        @(negedge clk);
        rdy = in_ready; ov = out_valid; got_nat = nature; got_err = out_step_err;
        stk = err_sticky; exp_stk = m_sticky; occ = exp_q.size();
        exp_nat = 'x; exp_err = 1'bx;
        if (ov && ordy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_nat = e.nat; exp_err = e.err;
        end
        acc_err = 1'b0;
        if (v && rdy) begin
            acc_err = m_armed && !clr && ($countones(g ^ m_prev) > 1);
            e.nat = nature_of(g); e.err = acc_err;
            exp_q.push_back(e);
            m_prev = g;
        end
        if (clr) begin
            m_sticky = 1'b0;
            m_armed  = v && rdy;
        end else if (v && rdy) begin
            m_armed = 1'b1;
            if (acc_err) m_sticky = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (nature !== '0) begin errors++; $display("FAIL reset_nature: got %0d exp 0", nature); end
        checks++; if (out_step_err !== 1'b0) begin errors++; $display("FAIL reset_step_err: got %b exp 0", out_step_err); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b exp 0", err_sticky); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic rdy, ov, ge, ee, stk, es;
        logic [W-1:0] gn, en;
        int occ;
        bit seen;
        do_reset();
        step(1'b1, 5'b01101, 1'b0, 1'b1, rdy, ov, gn, ge, en, ee, stk, es, occ);
        seen = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            step(1'b0, '0, 1'b0, 1'b1, rdy, ov, gn, ge, en, ee, stk, es, occ);
            if (ov) begin
                seen = 1;
                checks++; if (k != S) begin errors++; $display("FAIL single_latency: got %0d exp %0d", k, S); end
                checks++; if (gn !== 5'd9 || ge !== 1'b0) begin errors++; $display("FAIL single_word: got %0d/%b exp 9/0", gn, ge); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL single_timeout: got no word exp 1 word"); end
    endtask

    task automatic test_sweep();
        logic rdy, ov, ge, ee, stk, es;
        logic [W-1:0] gn, en;
        int occ, n, first;
        do_reset();
        n = 0; first = -1;
        for (int t = 0; t < 45 && n < 33; t++) begin
            step(t <= 32, gray_of(t % 32), 1'b0, 1'b1, rdy, ov, gn, ge, en, ee, stk, es, occ);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sweep_ready t=%0d: got %b exp 1", t, rdy); end
            if (ov) begin
                if (first < 0) first = t;
                checks++;
                if (gn !== W'(n % 32) || ge !== 1'b0 || gn !== en || t != first + n) begin
                    errors++;
                    $display("FAIL sweep_word %0d: got %0d/%b at t=%0d exp %0d/0 at t=%0d", n, gn, ge, t, n % 32, first + n);
                end
                n++;
            end
        end
        checks++; if (n != 33) begin errors++; $display("FAIL sweep_count: got %0d exp 33", n); end
    endtask

    task automatic test_backpressure();
        logic rdy, ov, ge, ee, stk, es, ordy, prev_stall, prev_err;
        logic [W-1:0] gn, en, prev_nat;
        int occ, n, i, lows;
        do_reset();
        n = 0; i = 0; lows = 0; prev_stall = 0; prev_nat = '0; prev_err = 0;
        for (int t = 0; t < 80 && n < 33; t++) begin
            ordy = !(t >= 8 && t < 13);
            step(i <= 32, gray_of(i % 32), 1'b0, ordy, rdy, ov, gn, ge, en, ee, stk, es, occ);
            checks++;
            if (rdy !== (ordy || occ < S)) begin
                errors++; $display("FAIL bp_ready t=%0d: got %b exp %b", t, rdy, (ordy || occ < S));
            end
            if (!rdy) lows++;
            if (prev_stall) begin
                checks++;
                if (ov !== 1'b1 || gn !== prev_nat || ge !== prev_err) begin
                    errors++; $display("FAIL bp_hold t=%0d: got %b/%0d/%b exp 1/%0d/%b", t, ov, gn, ge, prev_nat, prev_err);
                end
            end
            prev_stall = ov && !ordy; prev_nat = gn; prev_err = ge;
            if (ov && ordy) begin
                checks++;
                if (gn !== W'(n % 32) || gn !== en || ge !== 1'b0) begin
                    errors++; $display("FAIL bp_word %0d: got %0d/%b exp %0d/0", n, gn, ge, n % 32);
                end
                n++;
            end
            if (i <= 32 && rdy) i++;
        end
        checks++; if (n != 33) begin errors++; $display("FAIL bp_count: got %0d exp 33", n); end
        checks++; if (lows == 0) begin errors++; $display("FAIL bp_ready_drop: got 0 low cycles exp >0"); end
    endtask

    task automatic test_step_err();
        logic rdy, ov, ge, ee, stk, es;
        logic [W-1:0] gn, en;
        int occ, n;
        logic [W-1:0] sg  [10] = '{5'b00000, 5'b00011, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b11111, 5'b0, 5'b0, 5'b0};
        logic         sv  [10] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        logic         sc  [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic         sst [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        logic         werr[4]  = '{0, 1, 0, 0};
        do_reset();
        n = 0;
        for (int t = 0; t < 10; t++) begin
            step(sv[t], sg[t], sc[t], 1'b1, rdy, ov, gn, ge, en, ee, stk, es, occ);
            checks++;
            if (stk !== sst[t] || stk !== es) begin errors++; $display("FAIL stepe_sticky t=%0d: got %b exp %b", t, stk, sst[t]); end
            if (ov) begin
                checks++;
                if (n > 3 || gn !== en || ge !== werr[n]) begin
                    errors++; $display("FAIL stepe_word %0d: got %0d/%b exp %0d/%b", n, gn, ge, en, (n > 3) ? 1'bx : werr[n]);
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL stepe_count: got %0d exp 4", n); end
    endtask

    task automatic test_reset_mid();
        logic rdy, ov, ge, ee, stk, es;
        logic [W-1:0] gn, en;
        int occ;
        bit seen;
        do_reset();
        step(1'b1, 5'b00001, 1'b0, 1'b0, rdy, ov, gn, ge, en, ee, stk, es, occ);
        step(1'b1, 5'b00000, 1'b0, 1'b0, rdy, ov, gn, ge, en, ee, stk, es, occ);
        checks++; if (exp_q.size() != 2) begin errors++; $display("FAIL rmid_inflight: got %0d exp 2", exp_q.size()); end
        do_reset();
        for (int t = 0; t < 4; t++) begin
            step(1'b0, '0, 1'b0, 1'b1, rdy, ov, gn, ge, en, ee, stk, es, occ);
            checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rmid_stale t=%0d: got out_valid %b exp 0", t, ov); end
        end
        step(1'b1, 5'b10101, 1'b0, 1'b1, rdy, ov, gn, ge, en, ee, stk, es, occ);
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            step(1'b0, '0, 1'b0, 1'b1, rdy, ov, gn, ge, en, ee, stk, es, occ);
            if (ov) begin
                seen = 1;
                checks++; if (gn !== 5'd25 || ge !== 1'b0) begin errors++; $display("FAIL rmid_first: got %0d/%b exp 25/0", gn, ge); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rmid_timeout: got no word exp 1 word"); end
    endtask

    task automatic test_random();
        logic rdy, ov, ge, ee, stk, es, v, ordy, clr;
        logic [W-1:0] gn, en, g, last_g;
        int occ, r;
        do_reset();
        last_g = '0;
        for (int t = 0; t < 420; t++) begin
            v    = (t < 400) && ($urandom_range(0, 3) != 0);
            ordy = (t >= 400) || ($urandom_range(0, 3) != 0);
            clr  = (t < 400) && ($urandom_range(0, 19) == 0);
            r = $urandom_range(0, 3);
            if (r == 0) g = W'($urandom);
            else if (r == 1) g = last_g;
            else g = last_g ^ (W'(1) << $urandom_range(0, W - 1));
            last_g = g;
            step(v, g, clr, ordy, rdy, ov, gn, ge, en, ee, stk, es, occ);
            checks++;
            if (rdy !== (ordy || occ < S) || stk !== es) begin
                errors++; $display("FAIL rand_ctl t=%0d: got rdy %b stk %b exp rdy %b stk %b", t, rdy, stk, (ordy || occ < S), es);
            end
            if (ov && ordy) begin
                checks++;
                if (gn !== en || ge !== ee) begin errors++; $display("FAIL rand_word t=%0d: got %0d/%b exp %0d/%b", t, gn, ge, en, ee); end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_corners();
        int n1, n5;
        do_reset();
        n1 = 0; n5 = 0;
        for (int t = 0; t < 45; t++) begin
            c_valid = (t < 32); c_grey = gray_of(t % 32);
            @(negedge clk);
            checks++; if (c1_ready !== 1'b1 || c5_ready !== 1'b1) begin errors++; $display("FAIL corner_ready t=%0d: got %b/%b exp 1/1", t, c1_ready, c5_ready); end
            if (c1_ov) begin
                checks++;
                if (c1_nat !== W'(n1) || c1_serr !== 1'b0 || t != n1 + 1) begin
                    errors++; $display("FAIL corner_s1 %0d: got %0d/%b at t=%0d exp %0d/0 at t=%0d", n1, c1_nat, c1_serr, t, n1, n1 + 1);
                end
                n1++;
            end
            if (c5_ov) begin
                checks++;
                if (c5_nat !== W'(n5) || c5_serr !== 1'b0 || t != n5 + W) begin
                    errors++; $display("FAIL corner_s5 %0d: got %0d/%b at t=%0d exp %0d/0 at t=%0d", n5, c5_nat, c5_serr, t, n5, n5 + W);
                end
                n5++;
            end
            @(posedge clk); #1;
        end
        c_valid = 1'b0;
        checks++; if (n1 != 32 || n5 != 32) begin errors++; $display("FAIL corner_count: got %0d/%0d exp 32/32", n1, n5); end
        checks++; if (c1_stk !== 1'b0 || c5_stk !== 1'b0) begin errors++; $display("FAIL corner_sticky: got %b/%b exp 0/0", c1_stk, c5_stk); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        grey = '0; c_valid = 1'b0; c_grey = '0;
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_step_err();
        test_reset_mid();
        test_random();
        test_corners();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grey2nature.md
# grey2nature

Pipelined Gray-to-binary decoder with valid/ready flow control and single-step integrity checking. It sits on the receive side of Gray-coded buses produced by the team's binary-to-Gray encoder, such as counter snapshots and pointer samples. It restores the natural binary value and flags any sample that moved more than one Gray bit from the previously accepted sample.

## Interface
- WIDTH, 5, code width in bits (≥2)
- STAGES, 2, pipeline depth in register stages (1..WIDTH)
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  grey word offered
- in_ready  output  1  decoder can accept this cycle
- grey  input  WIDTH  Gray-coded input word
- err_clr  input  1  clears err_sticky and re-arms first-sample state
- out_valid  output  1  nature word available
- out_ready  input  1  consumer takes word this cycle
- nature  output  WIDTH  decoded binary value
- out_step_err  output  1  step error flag aligned with nature
- err_sticky  output  1  set on any step error, held until err_clr or reset

## Operation
- Decode: nature[WIDTH-1] = grey[WIDTH-1]; nature[i] = nature[i+1] ^ grey[i], MSB to LSB.
- Partition: C = ceil(WIDTH/STAGES). Stage s resolves bits WIDTH-1-s·C down to max(WIDTH-(s+1)·C, 0). Stages with no bits left pass data through. Each stage registers its resolved bits, its unresolved Gray bits, its valid bit and its err bit.
- Accept: a transfer occurs when in_valid && in_ready. Output: a transfer occurs when out_valid && out_ready.
- Stage advance: stage s loads when stage s is empty or stage s+1 loads (or, for the last stage, out_ready). in_ready = stage0 empty or stage0 advancing. This combinational ready chain gives 1 word/cycle with no bubbles.
- Step check at accept:
  - d = popcount(grey ^ prev_grey).
  - err = armed && (d > 1). d = 0 (repeat) and d = 1 are legal.
  - prev_grey updates on every accept.
  - armed is set by the first accept after reset or err_clr.
  - The first sample never errors.
- err_sticky:
  - Set in the cycle after any accept with err = 1.
  - err_clr has priority over a same-cycle set: the result is cleared and the current sample is treated as first.
- Wrap-around: Gray max (1 followed by zeros) to 0 is one bit and is legal.
- Reset values: all stage valids 0, out_valid 0, nature 0, out_step_err 0, err_sticky 0, prev_grey 0, armed 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: in-flight words are discarded and not delivered.

## Timing
- Latency: STAGES cycles from accept to out_valid when out_ready is held high.
- Throughput: one word per cycle sustained.
- Backpressure:
  - While out_ready = 0, nature and out_step_err are stable and out_valid stays high.
  - After STAGES words are buffered, in_ready drops in the same cycle.
- Simultaneous accept and deliver on a full pipeline is allowed and loses no word.
- in_ready depends combinationally on out_ready. No other input-to-output combinational path exists.

## Structure
- Shared package (grey_pkg): a popcount function and a Gray-to-binary function for a bit slice with a carried MSB. The binary-to-Gray encoder shares the same package.
- Sub-module grey2nature_stage: one pipeline register stage (valid, slice decode, hold). It is instantiated STAGES times via generate. The step checker and sticky logic stay in the top.

## Test plan
- Single word, WIDTH=5, STAGES=2: grey 5'b01101 -> nature 5'd9 after 2 cycles, out_step_err 0.
- Sweep: feed Gray codes of 0..31 then 0, back to back with out_ready = 1 -> nature 0..31, 0 in order, one per cycle. No out_step_err, including at the 10000 -> 00000 wrap.
- Backpressure: out_ready = 0 for 5 cycles during the sweep -> in_ready low after 2 buffered words, no loss or duplication, outputs stable while stalled.
- Step error: 00000 then 00011 -> second word has out_step_err 1 and err_sticky rises. Next word 00001 -> out_step_err 0 and err_sticky stays 1. Pulse err_clr -> err_sticky 0, and the next sample, 11111, does not error.
- Reset mid-stream: rst_n low for one cycle with 2 words in flight -> out_valid 0 and no stale word delivered. The first post-reset sample, 10101, does not error.
- Parameter corners: STAGES=1 and STAGES=WIDTH -> exhaustive decode correct, latency 1 and WIDTH respectively.
